instr_fetch_unit: RTL

- Producer side of the instruction-register load interface: fetches instructions from instruction memory and presents them as read_data with ir_load to the IR.
- Holds the fetch PC and issues word-addressed reads over a req/gnt/rvalid handshake with variable latency.
- Buffers returned words in a small in-order FIFO, so the control unit can load the IR every cycle despite memory latency.
- On a branch redirect, discards the FIFO contents and all in-flight responses.

---
 rtl/sisc_pkg.sv | 14 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sisc_pkg.sv
// Shared fetch-path types and constants for the instruction fetch unit and the IR consumer.
package sisc_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 16;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: registered storage, head visible combinationally, one cycle push-to-pop.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they were written.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, credit-limited imem requests and in-order instruction buffer feeding the IR; no bypass from empty.
// Backpressure: requests stop once buffered + outstanding words reach DEPTH; redirect flushes and drops in-flight replies.
module instr_fetch_unit
    import sisc_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redirect,
    input  logic [ADDR_W-1:0]    i_redirect_pc,
    input  logic                 i_next_instr,
    output logic                 o_ir_load,
    output logic [INSTR_W-1:0]   o_read_data,
    output logic [ADDR_W-1:0]    o_instr_pc,
    output logic                 o_imem_req,
    output logic [ADDR_W-1:0]    o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [INSTR_W-1:0]   i_imem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] SLOT_LIMIT = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;

    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;
    entry_t            w_head;
    entry_t            w_push_entry;

    logic [ADDR_W-1:0] w_tag_pc;
    logic [CW-1:0]     w_tag_count;
    logic              w_tag_empty;
    logic              w_tag_full;

    logic [CW:0]       w_slots;
    logic              w_req;
    logic              w_grant;
    logic              w_rsp;
    logic              w_keep;
    logic              w_load;
    logic              w_unused;

    assign w_slots = {1'b0, w_count} + {1'b0, r_outstanding};
    assign w_req   = !i_rst && !i_redirect && (w_slots < SLOT_LIMIT);
    assign w_grant = w_req && i_imem_gnt;

    // A reply with nothing outstanding belongs to a request abandoned by reset.
    assign w_rsp   = i_imem_rvalid && (r_outstanding != '0);
    assign w_keep  = w_rsp && (r_drop_cnt == '0) && !i_redirect;
    assign w_load  = i_next_instr && !w_empty && !i_redirect;

    assign w_push_entry.pc    = w_tag_pc;
    assign w_push_entry.instr = i_imem_rdata;

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_ir_load   = w_load;
    assign o_read_data = w_empty ? '0 : w_head.instr;
    assign o_instr_pc  = w_empty ? '0 : w_head.pc;

    assign w_unused = &{1'b0, w_full, w_tag_full, w_tag_empty, w_tag_count};

    // Address tags of live requests, popped as their replies are buffered; dropped replies never had a tag here.
    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_redirect),
        .i_push  (w_grant),
        .i_data  (r_pc),
        .i_pop   (w_keep),
        .o_data  (w_tag_pc),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_count)
    );

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_redirect),
        .i_push  (w_keep),
        .i_data  (w_push_entry),
        .i_pop   (w_load),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= ADDR_W'(RESET_PC);
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (i_redirect) begin
            // Everything still in flight after this cycle's reply is stale.
            r_pc          <= i_redirect_pc;
            r_outstanding <= r_outstanding - CW'(w_rsp);
            r_drop_cnt    <= r_outstanding - CW'(w_rsp);
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
            if (w_rsp && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

endmodule
